motor_pwm_array: RTL and testbench

Parametrised multi-channel H-bridge PWM engine that replaces the two fixed `pwm_generator` instances beside `Line_Following`. It accepts per-channel drive commands (mode, direction, duty) over a valid/ready handshake. It ramps each channel's duty toward its target once per PWM period and enforces a zero-duty dead interval on direction reversal. A global emergency stop from `Fault_detection` brakes every channel immediately.

---
 rtl/motor_pwm_pkg.sv | 30 +++
 rtl/motor_pwm_channel.sv | 205 ++++++++++++++++++++
 rtl/motor_pwm_array.sv | 102 ++++++++++
 tb/tb_motor_pwm_array.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg
//   Shared definitions for the multi-channel H-bridge PWM engine:
//   command mode encodings, the per-channel state enum, and a helper
//   that sizes the channel-select field.
package motor_pwm_pkg;

  // Command mode encodings (cmd_mode). 2'b11 is reserved and behaves as coast.
  localparam logic [1:0] MODE_COAST = 2'b00;
  localparam logic [1:0] MODE_DRIVE = 2'b01;
  localparam logic [1:0] MODE_BRAKE = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // Per-channel operating state.
  typedef enum logic [2:0] {
    ST_COAST    = 3'd0,
    ST_BRAKE    = 3'd1,
    ST_RUN      = 3'd2,
    ST_REV_RAMP = 3'd3,
    ST_DEAD     = 3'd4
  } ch_state_e;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_width(input int channels);
    if (channels <= 1) begin
      return 1;
    end
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// motor_pwm_channel
//   One H-bridge channel: drive/brake/coast FSM, once-per-period duty ramp,
//   zero-duty dead interval on direction reversal, and registered pin encoder.
//
// Ports
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   estop_i         : level, forces BRAKE and clears all pending work
//   cmd_hit_i       : an accepted command addresses this channel this cycle
//   cmd_mode_i      : command mode (coast / drive / brake / reserved)
//   cmd_dir_i       : requested direction (0 forward, 1 reverse)
//   cmd_duty_i      : requested target duty
//   strobe_i        : PWM period wrap pulse; ramp and dead count advance here
//   pwm_cnt_i       : shared PWM counter
//   motor_a_o/_b_o  : registered H-bridge inputs
//   busy_o          : ramping, reversing, or in dead time
module motor_pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int DUTY_W       = 5,
  parameter int RAMP_STEP    = 1,
  parameter int DEAD_PERIODS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              estop_i,
  input  logic              cmd_hit_i,
  input  logic [1:0]        cmd_mode_i,
  input  logic              cmd_dir_i,
  input  logic [DUTY_W-1:0] cmd_duty_i,
  input  logic              strobe_i,
  input  logic [DUTY_W-1:0] pwm_cnt_i,
  output logic              motor_a_o,
  output logic              motor_b_o,
  output logic              busy_o
);

  // Dead counter counts 0..DEAD_PERIODS-1; DEAD_PERIODS is expected to be >= 1.
  localparam int DC_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'((DEAD_PERIODS > 0) ? DEAD_PERIODS - 1 : 0);
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);

  ch_state_e         state_q, state_d;
  logic              dir_q, dir_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pend_dir_q, pend_dir_d;
  logic [DUTY_W-1:0] pend_target_q, pend_target_d;
  logic [DC_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic              motor_a_q, motor_a_d;
  logic              motor_b_q, motor_b_d;
  logic              pwm_bit;

  // Move cur toward tgt by at most STEP, landing exactly on tgt.
  function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (cur < tgt) begin
      return ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
    end else if (cur > tgt) begin
      return ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
    end
    return cur;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_COAST;
      dir_q         <= 1'b0;
      target_q      <= '0;
      duty_q        <= '0;
      pend_dir_q    <= 1'b0;
      pend_target_q <= '0;
      dead_cnt_q    <= '0;
      motor_a_q     <= 1'b0;
      motor_b_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      target_q      <= target_d;
      duty_q        <= duty_d;
      pend_dir_q    <= pend_dir_d;
      pend_target_q <= pend_target_d;
      dead_cnt_q    <= dead_cnt_d;
      motor_a_q     <= motor_a_d;
      motor_b_q     <= motor_b_d;
    end
  end

  // Priority: estop, then a command, then the period strobe. A command that
  // lands on the strobe cycle suppresses that cycle's ramp/dead step.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    target_d      = target_q;
    duty_d        = duty_q;
    pend_dir_d    = pend_dir_q;
    pend_target_d = pend_target_q;
    dead_cnt_d    = dead_cnt_q;

    if (estop_i) begin
      state_d       = ST_BRAKE;
      target_d      = '0;
      duty_d        = '0;
      pend_dir_d    = 1'b0;
      pend_target_d = '0;
      dead_cnt_d    = '0;
    end else if (cmd_hit_i) begin
      if (cmd_mode_i == MODE_DRIVE) begin
        case (state_q)
          ST_RUN: begin
            if (cmd_dir_i == dir_q) begin
              target_d = cmd_duty_i;
            end else begin
              // Reversal: wind down under the old direction first.
              pend_dir_d    = cmd_dir_i;
              pend_target_d = cmd_duty_i;
              target_d      = '0;
              dead_cnt_d    = '0;
              state_d       = (duty_q != '0) ? ST_REV_RAMP : ST_DEAD;
            end
          end
          ST_REV_RAMP, ST_DEAD: begin
            if (cmd_dir_i == dir_q) begin
              // Reversal cancelled; resume ramping from wherever duty is now.
              state_d       = ST_RUN;
              target_d      = cmd_duty_i;
              pend_dir_d    = 1'b0;
              pend_target_d = '0;
              dead_cnt_d    = '0;
            end else begin
              pend_dir_d    = cmd_dir_i;
              pend_target_d = cmd_duty_i;
            end
          end
          default: begin
            // From COAST or BRAKE the ramp always starts at zero.
            state_d       = ST_RUN;
            dir_d         = cmd_dir_i;
            target_d      = cmd_duty_i;
            duty_d        = '0;
            pend_dir_d    = 1'b0;
            pend_target_d = '0;
            dead_cnt_d    = '0;
          end
        endcase
      end else begin
        state_d       = (cmd_mode_i == MODE_BRAKE) ? ST_BRAKE : ST_COAST;
        target_d      = '0;
        duty_d        = '0;
        pend_dir_d    = 1'b0;
        pend_target_d = '0;
        dead_cnt_d    = '0;
      end
    end else if (strobe_i) begin
      case (state_q)
        ST_RUN: begin
          duty_d = ramp_toward(duty_q, target_q);
        end
        ST_REV_RAMP: begin
          duty_d = ramp_toward(duty_q, '0);
          if (duty_d == '0) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q == DEAD_LAST) begin
            state_d       = ST_RUN;
            dir_d         = pend_dir_q;
            target_d      = pend_target_q;
            pend_dir_d    = 1'b0;
            pend_target_d = '0;
            dead_cnt_d    = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + DC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pin encoder; DEAD and COAST both float the bridge.
  always_comb begin
    pwm_bit   = (pwm_cnt_i < duty_q);
    motor_a_d = 1'b0;
    motor_b_d = 1'b0;
    case (state_q)
      ST_RUN, ST_REV_RAMP: begin
        motor_a_d = dir_q ? 1'b0 : pwm_bit;
        motor_b_d = dir_q ? pwm_bit : 1'b0;
      end
      ST_BRAKE: begin
        motor_a_d = 1'b1;
        motor_b_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign motor_a_o = motor_a_q;
  assign motor_b_o = motor_b_q;
  assign busy_o    = (state_q == ST_REV_RAMP) || (state_q == ST_DEAD) ||
                     ((state_q == ST_RUN) && (duty_q != target_q));

endmodule

// File: rtl/motor_pwm_array.sv
// motor_pwm_array
//   Multi-channel H-bridge PWM engine. Owns the prescaler, the shared PWM
//   counter, period strobe generation and command decode; each channel's
//   FSM lives in motor_pwm_channel.
//
// Ports
//   clk_50M        : clock
//   reset          : asynchronous active-high reset
//   estop          : level emergency stop, brakes every channel
//   cmd_valid      : command present
//   cmd_ready      : command accepted when valid and ready on a rising edge
//   cmd_ch         : target channel (out-of-range values are swallowed)
//   cmd_mode       : 00 coast, 01 drive, 10 brake, 11 coast
//   cmd_dir        : 0 forward, 1 reverse
//   cmd_duty       : target duty
//   motor_a/_b     : registered H-bridge inputs, one bit per channel
//   busy           : per-channel ramping / reversing / dead time
//   period_strobe  : one-cycle pulse on each PWM period wrap
module motor_pwm_array
  import motor_pwm_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int DUTY_W       = 5,
  parameter int PRESCALE     = 16,
  parameter int RAMP_STEP    = 1,
  parameter int DEAD_PERIODS = 4,
  localparam int CH_W        = ch_width(CHANNELS)
) (
  input  logic                clk_50M,
  input  logic                reset,
  input  logic                estop,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [1:0]          cmd_mode,
  input  logic                cmd_dir,
  input  logic [DUTY_W-1:0]   cmd_duty,
  output logic [CHANNELS-1:0] motor_a,
  output logic [CHANNELS-1:0] motor_b,
  output logic [CHANNELS-1:0] busy,
  output logic                period_strobe
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                tick;
  logic                cmd_accept;
  logic [CHANNELS-1:0] cmd_hit;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  always_comb begin
    tick      = (presc_q == PS_LAST);
    presc_d   = tick ? '0 : (presc_q + PS_W'(1));
    pwm_cnt_d = tick ? (pwm_cnt_q + DUTY_W'(1)) : pwm_cnt_q;
  end

  // The wrap tick is the last tick of the period, so ramp updates written on
  // it take effect from counter value 0 of the next period.
  assign period_strobe = tick && (&pwm_cnt_q);

  assign cmd_ready  = !estop;
  assign cmd_accept = cmd_valid && !estop;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // A channel index beyond CHANNELS-1 matches no channel and is dropped.
      assign cmd_hit[gi] = cmd_accept && (cmd_ch == CH_W'(gi));

      motor_pwm_channel #(
        .DUTY_W       (DUTY_W),
        .RAMP_STEP    (RAMP_STEP),
        .DEAD_PERIODS (DEAD_PERIODS)
      ) u_ch (
        .clk_i      (clk_50M),
        .rst_i      (reset),
        .estop_i    (estop),
        .cmd_hit_i  (cmd_hit[gi]),
        .cmd_mode_i (cmd_mode),
        .cmd_dir_i  (cmd_dir),
        .cmd_duty_i (cmd_duty),
        .strobe_i   (period_strobe),
        .pwm_cnt_i  (pwm_cnt_q),
        .motor_a_o  (motor_a[gi]),
        .motor_b_o  (motor_b[gi]),
        .busy_o     (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_motor_pwm_array.sv
// tb_motor_pwm_array
//   Directed bench: three channels (so channel index 3 is out of range),
//   5-bit duty, prescale 2, giving a 64-cycle PWM period.
module tb_motor_pwm_array;

  localparam int CH  = 3;
  localparam int DW  = 5;
  localparam int PS  = 2;
  localparam int PER = PS * (1 << DW);

  logic          clk_50M = 1'b0;
  logic          reset = 1'b1;
  logic          estop = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_ch = '0;
  logic [1:0]    cmd_mode = '0;
  logic          cmd_dir = 1'b0;
  logic [DW-1:0] cmd_duty = '0;
  logic [CH-1:0] motor_a;
  logic [CH-1:0] motor_b;
  logic [CH-1:0] busy;
  logic          period_strobe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int overlap_cnt = 0;

  motor_pwm_array #(
    .CHANNELS     (CH),
    .DUTY_W       (DW),
    .PRESCALE     (PS),
    .RAMP_STEP    (1),
    .DEAD_PERIODS (4)
  ) dut (
    .clk_50M       (clk_50M),
    .reset         (reset),
    .estop         (estop),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ch        (cmd_ch),
    .cmd_mode      (cmd_mode),
    .cmd_dir       (cmd_dir),
    .cmd_duty      (cmd_duty),
    .motor_a       (motor_a),
    .motor_b       (motor_b),
    .busy          (busy),
    .period_strobe (period_strobe)
  );

  always #5 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (mon_en && motor_a[1] && motor_b[1]) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Returns at the negedge just after a strobe edge has been applied.
  task automatic wait_strobe();
    int n = 0;
    while (!period_strobe && n < 4 * PER) begin
      @(negedge clk_50M);
      n++;
    end
    chk("strobe_seen", {31'd0, period_strobe}, 32'd1);
    @(negedge clk_50M);
  endtask

  task automatic measure(input int ch, output int a_cnt, output int b_cnt);
    wait_strobe();
    a_cnt = 0;
    b_cnt = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk_50M);
      a_cnt += int'(motor_a[ch]);
      b_cnt += int'(motor_b[ch]);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [1:0] mode,
                      input logic dir, input logic [DW-1:0] duty);
    cmd_ch    = ch;
    cmd_mode  = mode;
    cmd_dir   = dir;
    cmd_duty  = duty;
    cmd_valid = 1'b1;
    $display("cmd ch=%0d mode=%0d dir=%0d duty=%0d", ch, mode, dir, duty);
    @(negedge clk_50M);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int a_cnt, b_cnt, c1, c2;

    // Reset values
    repeat (3) @(negedge clk_50M);
    chk("rst_motor_a", {29'd0, motor_a}, 32'd0);
    chk("rst_motor_b", {29'd0, motor_b}, 32'd0);
    chk("rst_busy", {29'd0, busy}, 32'd0);
    chk("rst_strobe", {31'd0, period_strobe}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b0;

    // Strobe spacing
    wait_strobe();
    c1 = cyc;
    wait_strobe();
    c2 = cyc;
    chk("strobe_period", c2 - c1, PER);

    // ch0 forward duty 16, ramps 1 per period
    send(2'd0, 2'b01, 1'b0, 5'd16);
    chk("ch0_busy_start", {31'd0, busy[0]}, 32'd1);
    repeat (15) wait_strobe();
    chk("ch0_busy_15", {31'd0, busy[0]}, 32'd1);
    wait_strobe();
    chk("ch0_busy_16", {31'd0, busy[0]}, 32'd0);
    measure(0, a_cnt, b_cnt);
    chk("ch0_a_high", a_cnt, 16 * PS);
    chk("ch0_b_high", b_cnt, 0);

    // ch1 forward 8, then reverse 8
    send(2'd1, 2'b01, 1'b0, 5'd8);
    repeat (8) wait_strobe();
    chk("ch1_fwd_busy", {31'd0, busy[1]}, 32'd0);
    measure(1, a_cnt, b_cnt);
    chk("ch1_fwd_a", a_cnt, 8 * PS);
    mon_en = 1'b1;
    send(2'd1, 2'b01, 1'b1, 5'd8);
    chk("ch1_rev_busy", {31'd0, busy[1]}, 32'd1);
    repeat (7) wait_strobe();
    chk("ch1_ramp_busy", {31'd0, busy[1]}, 32'd1);
    wait_strobe();
    chk("ch1_dead_busy", {31'd0, busy[1]}, 32'd1);
    measure(1, a_cnt, b_cnt);
    chk("ch1_dead_pins", a_cnt + b_cnt, 0);
    repeat (2) wait_strobe();
    chk("ch1_dead_b", {31'd0, motor_b[1]}, 32'd0);
    wait_strobe();
    repeat (7) wait_strobe();
    chk("ch1_up_busy7", {31'd0, busy[1]}, 32'd1);
    wait_strobe();
    chk("ch1_up_busy8", {31'd0, busy[1]}, 32'd0);
    measure(1, a_cnt, b_cnt);
    chk("ch1_rev_b", b_cnt, 8 * PS);
    chk("ch1_rev_a", a_cnt, 0);
    mon_en = 1'b0;
    chk("ch1_overlap", overlap_cnt, 0);

    // Brake ch0 mid-ramp
    send(2'd0, 2'b01, 1'b0, 5'd4);
    repeat (2) wait_strobe();
    chk("ch0_down_busy", {31'd0, busy[0]}, 32'd1);
    send(2'd0, 2'b10, 1'b0, 5'd0);
    chk("brk_lat1_b", {31'd0, motor_b[0]}, 32'd0);
    @(negedge clk_50M);
    chk("brk_a", {31'd0, motor_a[0]}, 32'd1);
    chk("brk_b", {31'd0, motor_b[0]}, 32'd1);
    chk("brk_busy", {31'd0, busy[0]}, 32'd0);

    // estop during DEAD on ch1, with a simultaneous command for ch2
    send(2'd1, 2'b01, 1'b0, 5'd8);
    repeat (9) wait_strobe();
    chk("ch1_in_dead", {31'd0, busy[1]}, 32'd1);
    estop     = 1'b1;
    cmd_ch    = 2'd2;
    cmd_mode  = 2'b01;
    cmd_dir   = 1'b0;
    cmd_duty  = 5'd5;
    cmd_valid = 1'b1;
    @(negedge clk_50M);
    chk("estop_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk_50M);
    chk("estop_a", {29'd0, motor_a}, 32'd7);
    chk("estop_b", {29'd0, motor_b}, 32'd7);
    chk("estop_busy", {29'd0, busy}, 32'd0);
    @(negedge clk_50M);
    estop     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) wait_strobe();
    chk("post_estop_a", {29'd0, motor_a}, 32'd7);
    chk("post_estop_b", {29'd0, motor_b}, 32'd7);
    chk("post_ready", {31'd0, cmd_ready}, 32'd1);
    send(2'd1, 2'b00, 1'b0, 5'd0);
    @(negedge clk_50M);
    chk("coast_a", {29'd0, motor_a}, 32'd5);
    chk("coast_b", {29'd0, motor_b}, 32'd5);

    // Out-of-range channel: accepted, no effect
    chk("oor_ready", {31'd0, cmd_ready}, 32'd1);
    send(2'd3, 2'b01, 1'b1, 5'd31);
    repeat (3) @(negedge clk_50M);
    chk("oor_a", {29'd0, motor_a}, 32'd5);
    chk("oor_b", {29'd0, motor_b}, 32'd5);
    chk("oor_busy", {29'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
